// File: rtl/vx_barrier_ctl_pkg.sv
// Shared configuration and types for the warp barrier controller (package VX_gpu_pkg).
// NUM_WARPS / NUM_BARRIERS may be overridden by config defines before this file.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif

package VX_gpu_pkg;

  localparam int CFG_NUM_WARPS    = `NUM_WARPS;
  localparam int CFG_NUM_BARRIERS = `NUM_BARRIERS;
  localparam int NW_BITS          = $clog2(CFG_NUM_WARPS);
  localparam int NB_BITS          = (CFG_NUM_BARRIERS > 1) ? $clog2(CFG_NUM_BARRIERS) : 1;

  typedef struct packed {
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } barrier_req_t;

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_COLLECT = 1'b1
  } slot_state_e;

endpackage

// File: rtl/vx_barrier_slot.sv
// One barrier slot: collects arriving warps and fires (combinationally) on the
// arrival that completes the expected count; the slot clears on that same edge.
module vx_barrier_slot
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS = CFG_NUM_WARPS,
  parameter int WID_BITS  = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [WID_BITS-1:0]  wid,
  input  logic [WID_BITS-1:0]  size_m1,
  output logic [NUM_WARPS-1:0] mask,
  output logic                 active,
  output logic                 fire,
  output logic [NUM_WARPS-1:0] fire_mask
);

  slot_state_e          state_q, state_d;
  logic [WID_BITS-1:0]  count_q, count_d;
  logic [WID_BITS-1:0]  size_q, size_d;
  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NUM_WARPS-1:0] wid_oh;

  assign wid_oh    = NUM_WARPS'(1) << wid;
  assign fire_mask = mask_q | wid_oh;
  assign mask      = mask_q;
  assign active    = (state_q == SLOT_COLLECT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_IDLE;
      count_q <= '0;
      size_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      size_q  <= size_d;
      mask_q  <= mask_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    size_d  = size_q;
    mask_d  = mask_q;
    fire    = 1'b0;
    unique case (state_q)
      SLOT_IDLE: begin
        if (arrive) begin
          size_d = size_m1;
          if (size_m1 == '0) begin
            fire = 1'b1;
          end else begin
            mask_d  = wid_oh;
            count_d = WID_BITS'(1);
            state_d = SLOT_COLLECT;
          end
        end
      end
      SLOT_COLLECT: begin
        if (arrive) begin
          if (count_q == size_q) begin
            fire    = 1'b1;
            mask_d  = '0;
            count_d = '0;
            state_d = SLOT_IDLE;
          end else begin
            mask_d  = mask_q | wid_oh;
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  // Later arrivals must agree with the size latched by the first one.
  a_size_match: assert property (@(posedge clk) disable iff (reset)
    (arrive && state_q == SLOT_COLLECT) |-> (size_m1 == size_q));

endmodule

// File: rtl/vx_barrier_ctl.sv
// Warp barrier controller: per-slot arrival tracking with a registered release pulse.
// Optional VX_BARRIER_PERF_EN adds the perf_bar_stalls counter output.
module vx_barrier_ctl
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS    = CFG_NUM_WARPS,
  parameter int NUM_BARRIERS = CFG_NUM_BARRIERS,
  parameter int WID_BITS     = $clog2(NUM_WARPS),
  parameter int BID_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bar_valid,
  input  logic [WID_BITS-1:0]     bar_wid,
  input  logic [BID_BITS-1:0]     bar_id,
  input  logic [WID_BITS-1:0]     bar_size_m1,
  output logic [NUM_WARPS-1:0]    stall_mask,
  output logic                    release_valid,
  output logic [NUM_WARPS-1:0]    release_mask,
  output logic [NUM_BARRIERS-1:0] bar_active
`ifdef VX_BARRIER_PERF_EN
  ,
  output logic [31:0]             perf_bar_stalls
`endif
);

  logic [NUM_BARRIERS-1:0] arrive;
  logic [NUM_BARRIERS-1:0] slot_fire;
  logic [NUM_WARPS-1:0]    slot_mask      [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_fire_mask [NUM_BARRIERS];
  logic                    rel_valid_d;
  logic [NUM_WARPS-1:0]    rel_mask_d;

  always_comb begin
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      arrive[i] = bar_valid && (bar_id == BID_BITS'(i));
    end
  end

  for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_slot
    vx_barrier_slot #(
      .NUM_WARPS (NUM_WARPS),
      .WID_BITS  (WID_BITS)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .arrive    (arrive[i]),
      .wid       (bar_wid),
      .size_m1   (bar_size_m1),
      .mask      (slot_mask[i]),
      .active    (bar_active[i]),
      .fire      (slot_fire[i]),
      .fire_mask (slot_fire_mask[i])
    );
  end

  // Slot masks are registers, so this OR is a clean function of state.
  always_comb begin
    stall_mask = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      stall_mask = stall_mask | slot_mask[i];
    end
  end

  // At most one slot fires per cycle, so an AND-OR mux is sufficient.
  always_comb begin
    rel_valid_d = |slot_fire;
    rel_mask_d  = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      if (slot_fire[i]) rel_mask_d = rel_mask_d | slot_fire_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      release_valid <= 1'b0;
      release_mask  <= '0;
    end else begin
      release_valid <= rel_valid_d;
      release_mask  <= rel_mask_d;
    end
  end

`ifdef VX_BARRIER_PERF_EN
  logic [WID_BITS:0] stall_cnt;
  logic [32:0]       perf_sum;

  always_comb begin
    stall_cnt = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      stall_cnt = stall_cnt + (WID_BITS+1)'(stall_mask[w]);
    end
    perf_sum = {1'b0, perf_bar_stalls} + 33'(stall_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) perf_bar_stalls <= '0;
    else       perf_bar_stalls <= perf_sum[32] ? 32'hFFFF_FFFF : perf_sum[31:0];
  end
`endif

  a_not_parked: assert property (@(posedge clk) disable iff (reset)
    bar_valid |-> !stall_mask[bar_wid]);

  if (NUM_BARRIERS < (1 << BID_BITS)) begin : g_id_chk
    a_id_range: assert property (@(posedge clk) disable iff (reset)
      bar_valid |-> (bar_id < BID_BITS'(NUM_BARRIERS)));
  end

  if (NUM_WARPS < (1 << WID_BITS)) begin : g_size_chk
    a_size_range: assert property (@(posedge clk) disable iff (reset)
      bar_valid |-> (bar_size_m1 < WID_BITS'(NUM_WARPS)));
  end

endmodule

// File: tb/tb_vx_barrier_ctl.sv
// Self-checking bench for vx_barrier_ctl: a set-based arrival model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_vx_barrier_ctl;

  localparam int NW = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bar_valid;
  logic [1:0]    bar_wid;
  logic [1:0]    bar_id;
  logic [1:0]    bar_size_m1;
  logic [NW-1:0] stall_mask;
  logic          release_valid;
  logic [NW-1:0] release_mask;
  logic [NB-1:0] bar_active;
`ifdef VX_BARRIER_PERF_EN
  logic [31:0]   perf_bar_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_barrier_ctl #(
    .NUM_WARPS    (NW),
    .NUM_BARRIERS (NB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bar_valid       (bar_valid),
    .bar_wid         (bar_wid),
    .bar_id          (bar_id),
    .bar_size_m1     (bar_size_m1),
    .stall_mask      (stall_mask),
    .release_valid   (release_valid),
    .release_mask    (release_mask),
    .bar_active      (bar_active)
`ifdef VX_BARRIER_PERF_EN
    ,
    .perf_bar_stalls (perf_bar_stalls)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot holds the set of parked warps and the size given by its first
  // arrival; an arrival completes the barrier when the parked set already holds size_m1 warps.
  logic [NW-1:0] m_parked [NB];
  logic [1:0]    m_size   [NB];
  logic          m_rv;
  logic [NW-1:0] m_rm;
  logic [31:0]   m_perf;
  logic [NW-1:0] m_stall;
  logic [NB-1:0] m_active;

  always_comb begin
    m_stall  = '0;
    m_active = '0;
    for (int i = 0; i < NB; i++) begin
      m_stall     = m_stall | m_parked[i];
      m_active[i] = (m_parked[i] != '0);
    end
  end

  always @(posedge clk) begin : model
    logic [NW-1:0] nxt [NB];
    logic [1:0]    sz  [NB];
    logic          rv;
    logic [NW-1:0] rm;
    logic [32:0]   psum;
    logic [31:0]   pn;
    nxt = m_parked;
    sz  = m_size;
    rv  = 1'b0;
    rm  = '0;
    pn  = m_perf;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        nxt[i] = '0;
        sz[i]  = '0;
      end
      pn = '0;
    end else begin
      psum = {1'b0, m_perf} + 33'($countones(m_stall));
      pn   = psum[32] ? 32'hFFFF_FFFF : psum[31:0];
      if (bar_valid) begin
        if (nxt[bar_id] == '0) sz[bar_id] = bar_size_m1;
        if ($countones(nxt[bar_id]) == int'(sz[bar_id])) begin
          rv          = 1'b1;
          rm          = nxt[bar_id] | (NW'(1) << bar_wid);
          nxt[bar_id] = '0;
        end else begin
          nxt[bar_id] = nxt[bar_id] | (NW'(1) << bar_wid);
        end
      end
    end
    m_parked <= nxt;
    m_size   <= sz;
    m_rv     <= rv;
    m_rm     <= rm;
    m_perf   <= pn;
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall_mask", 32'(stall_mask), 32'(m_stall));
      check("bar_active", 32'(bar_active), 32'(m_active));
      check("release_valid", 32'(release_valid), 32'(m_rv));
      if (m_rv) check("release_mask", 32'(release_mask), 32'(m_rm));
`ifdef VX_BARRIER_PERF_EN
      check("perf_bar_stalls", perf_bar_stalls, m_perf);
`endif
    end
  end

  // One arrival during a single cycle; returns 1 time unit after the sampling edge.
  task automatic arrive(input int wid, input int id, input int size_m1);
    bar_valid   = 1'b1;
    bar_wid     = 2'(wid);
    bar_id      = 2'(id);
    bar_size_m1 = 2'(size_m1);
    @(posedge clk);
    #1;
    bar_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] p0;
    p0          = '0;
    reset       = 1'b1;
    bar_valid   = 1'b0;
    bar_wid     = '0;
    bar_id      = '0;
    bar_size_m1 = '0;
    tick(2);
    check("reset stall_mask", 32'(stall_mask), 32'h0);
    check("reset release_valid", 32'(release_valid), 32'h0);
    check("reset release_mask", 32'(release_mask), 32'h0);
    check("reset bar_active", 32'(bar_active), 32'h0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    tick(1);

    // Four warps on slot 0 with size 4.
    arrive(0, 0, 3); check("t1 stall a", 32'(stall_mask), 32'b0001);
    arrive(1, 0, 3); check("t1 stall b", 32'(stall_mask), 32'b0011);
    arrive(2, 0, 3); check("t1 stall c", 32'(stall_mask), 32'b0111);
    check("t1 active", 32'(bar_active), 32'b0001);
    arrive(3, 0, 3);
    check("t1 release_valid", 32'(release_valid), 32'h1);
    check("t1 release_mask", 32'(release_mask), 32'b1111);
    check("t1 stall after", 32'(stall_mask), 32'b0000);
    tick(1);
    check("t1 pulse ends", 32'(release_valid), 32'h0);

    // Size-one barrier releases immediately.
    arrive(2, 1, 0);
    check("t2 release_mask", 32'(release_mask), 32'b0100);
    check("t2 release_valid", 32'(release_valid), 32'h1);
    check("t2 stall", 32'(stall_mask), 32'b0000);
    check("t2 active", 32'(bar_active), 32'b0000);
    tick(1);

    // Interleaved barriers releasing on consecutive cycles.
    arrive(0, 0, 1);
    arrive(2, 1, 1);
    check("t3 active", 32'(bar_active), 32'b0011);
    arrive(1, 0, 1);
    check("t3 first release", 32'(release_mask), 32'b0011);
    check("t3 stall mid", 32'(stall_mask), 32'b0100);
    arrive(3, 1, 1);
    check("t3 second valid", 32'(release_valid), 32'h1);
    check("t3 second release", 32'(release_mask), 32'b1100);
    tick(1);

    // Re-arm: arrival the cycle after a release is a fresh first arrival.
    arrive(0, 0, 1);
    arrive(2, 0, 1);
    check("t4 release", 32'(release_mask), 32'b0101);
    arrive(1, 0, 1);
    check("t4 no release", 32'(release_valid), 32'h0);
    check("t4 stall", 32'(stall_mask), 32'b0010);
    arrive(3, 0, 1);
    check("t4 second release", 32'(release_mask), 32'b1010);
    tick(1);

    // Reset drops parked warps without a release.
    arrive(0, 2, 3);
    arrive(1, 2, 3);
    check("t5 stall parked", 32'(stall_mask), 32'b0011);
    check("t5 active", 32'(bar_active), 32'b0100);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5 reset stall", 32'(stall_mask), 32'h0);
    check("t5 reset active", 32'(bar_active), 32'h0);
    check("t5 reset release", 32'(release_valid), 32'h0);
    tick(1);
    check("t5 no pulse", 32'(release_valid), 32'h0);
    arrive(2, 2, 0);
    check("t5 lone release", 32'(release_mask), 32'b0100);
    check("t5 lone valid", 32'(release_valid), 32'h1);
    tick(1);

    // Two parked warps for ten cycles.
    arrive(0, 3, 3);
    arrive(1, 3, 3);
`ifdef VX_BARRIER_PERF_EN
    p0 = perf_bar_stalls;
`endif
    tick(10);
`ifdef VX_BARRIER_PERF_EN
    check("t6 perf delta", perf_bar_stalls - p0, 32'd20);
`endif
    check("t6 stall held", 32'(stall_mask), 32'b0011);
    arrive(2, 3, 3);
    arrive(3, 3, 3);
    check("t6 release", 32'(release_mask), 32'b1111);
    tick(3);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
